// File: rtl/unlock_seq.sv
// Magic-key unlock sequencer: PREFIX0, PREFIX1, personality magic, SUFFIX, then one committed config write.
// Optional consecutive-failure lockout is built when UNLOCK_SEQ_LOCKOUT_EN is defined.
module unlock_seq #(
  parameter int unsigned          WIDTH    = 8,
  parameter int unsigned          NUM_ID   = 2,
  parameter int unsigned          IDX_W    = 4,
  parameter logic [WIDTH-1:0]     PREFIX0  = 'h55,
  parameter logic [WIDTH-1:0]     PREFIX1  = 'hAA,
  parameter logic [WIDTH-1:0]     SUFFIX   = 'h01,
  parameter int unsigned          TIMEOUT  = 16,
  parameter int unsigned          MAX_FAIL = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    strobe,
  input  logic                    abort,
  input  logic [WIDTH-1:0]        data,
  input  logic [NUM_ID*WIDTH-1:0] magic,
  output logic [2:0]              state,
  output logic                    armed,
  output logic                    commit,
  output logic [IDX_W-1:0]        commit_id,
  output logic [WIDTH-1:0]        commit_data,
  output logic                    timeout,
  output logic                    fail,
  output logic                    locked
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_P0    = 3'd1,
    S_P1    = 3'd2,
    S_ID    = 3'd3,
    S_ARMED = 3'd4
  } state_t;

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic               armed_q, armed_d;
  logic               commit_q, commit_d;
  logic [IDX_W-1:0]   commit_id_q, commit_id_d;
  logic [WIDTH-1:0]   commit_data_q, commit_data_d;
  logic               timeout_q, timeout_d;
  logic               fail_q, fail_d;
  logic               lock_now;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               is_p0;
  state_t             miss_st;

  // Scan from the top down so the lowest matching personality is left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (data == magic[i*WIDTH +: WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign is_p0   = (data == PREFIX0);
  assign miss_st = is_p0 ? S_P0 : S_IDLE;

`ifdef UNLOCK_SEQ_LOCKOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_FAIL + 1);

  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             locked_q, locked_d;

  assign lock_now = locked_q;
`else
  assign lock_now = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    id_d          = id_q;
    commit_d      = 1'b0;
    commit_id_d   = commit_id_q;
    commit_data_d = commit_data_q;
    timeout_d     = 1'b0;
    fail_d        = 1'b0;

    if (lock_now) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else if (abort) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else if (strobe) begin
      timer_d = '0;
      case (state_q)
        S_IDLE: begin
          if (is_p0) state_d = S_P0;
        end
        S_P0: begin
          if (data == PREFIX1) begin
            state_d = S_P1;
          end else begin
            fail_d  = 1'b1;
            state_d = miss_st;
          end
        end
        S_P1: begin
          if (hit) begin
            state_d = S_ID;
            id_d    = hit_idx;
          end else begin
            fail_d  = 1'b1;
            state_d = miss_st;
          end
        end
        S_ID: begin
          if (data == SUFFIX) begin
            state_d = S_ARMED;
          end else begin
            fail_d  = 1'b1;
            state_d = miss_st;
          end
        end
        S_ARMED: begin
          state_d       = S_IDLE;
          commit_d      = 1'b1;
          commit_id_d   = id_q;
          commit_data_d = data;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: timer_d = '0;
        S_P0, S_P1, S_ID, S_ARMED: begin
          if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
            state_d   = S_IDLE;
            timer_d   = '0;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end

`ifdef UNLOCK_SEQ_LOCKOUT_EN
    fail_cnt_d = fail_cnt_q;
    locked_d   = locked_q;
    if (commit_d) begin
      fail_cnt_d = '0;
    end else if (fail_d) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
    if (!locked_q && fail_cnt_d >= CNT_W'(MAX_FAIL)) begin
      locked_d = 1'b1;
      state_d  = S_IDLE;
      timer_d  = '0;
    end
`endif

    armed_d = (state_d == S_ARMED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      id_q          <= '0;
      armed_q       <= 1'b0;
      commit_q      <= 1'b0;
      commit_id_q   <= '0;
      commit_data_q <= '0;
      timeout_q     <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      id_q          <= id_d;
      armed_q       <= armed_d;
      commit_q      <= commit_d;
      commit_id_q   <= commit_id_d;
      commit_data_q <= commit_data_d;
      timeout_q     <= timeout_d;
      fail_q        <= fail_d;
    end
  end

`ifdef UNLOCK_SEQ_LOCKOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign state       = state_q;
  assign armed       = armed_q;
  assign commit      = commit_q;
  assign commit_id   = commit_id_q;
  assign commit_data = commit_data_q;
  assign timeout     = timeout_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_unlock_seq.sv
// Directed bench for unlock_seq: commit, resync, timeout, abort, async reset
// and (with UNLOCK_SEQ_LOCKOUT_EN) lockout.
module tb_unlock_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  data = '0;
  logic [15:0] magic = 16'h1121;
  logic [2:0]  state;
  logic        armed;
  logic        commit;
  logic [3:0]  commit_id;
  logic [7:0]  commit_data;
  logic        timeout;
  logic        fail;
  logic        locked;

  int checks = 0;
  int errors = 0;

  unlock_seq #(
    .WIDTH(8), .NUM_ID(2), .IDX_W(4),
    .PREFIX0(8'h55), .PREFIX1(8'hAA), .SUFFIX(8'h01),
    .TIMEOUT(16), .MAX_FAIL(3)
  ) dut (
    .clock(clock), .reset(reset), .strobe(strobe), .abort(abort),
    .data(data), .magic(magic), .state(state), .armed(armed),
    .commit(commit), .commit_id(commit_id), .commit_data(commit_data),
    .timeout(timeout), .fail(fail), .locked(locked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic [7:0] d, input logic a);
    @(negedge clock);
    strobe = s;
    data   = d;
    abort  = a;
    @(posedge clock);
    #1;
    strobe = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_id", 32'(commit_id), 0);
    chk("rst_data", 32'(commit_data), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_locked", 32'(locked), 0);
    @(negedge clock);
    reset = 1'b0;

    // personality 1 full commit
    step(1, 8'h55, 0); chk("p1_s1", 32'(state), 1);
    step(1, 8'hAA, 0); chk("p1_s2", 32'(state), 2);
    step(1, 8'h11, 0); chk("p1_s3", 32'(state), 3);
    chk("p1_armed3", 32'(armed), 0);
    step(1, 8'h01, 0); chk("p1_s4", 32'(state), 4);
    chk("p1_armed4", 32'(armed), 1);
    step(1, 8'h3C, 0);
    chk("p1_commit", 32'(commit), 1);
    chk("p1_id", 32'(commit_id), 1);
    chk("p1_data", 32'(commit_data), 8'h3C);
    chk("p1_state", 32'(state), 0);
    chk("p1_armed5", 32'(armed), 0);
    idle(1);
    chk("p1_pulse", 32'(commit), 0);
    chk("p1_idhold", 32'(commit_id), 1);

    // resync on a repeated PREFIX0
    step(1, 8'h55, 0); chk("rs_fail1", 32'(fail), 0);
    step(1, 8'h55, 0);
    chk("rs_fail2", 32'(fail), 1);
    chk("rs_state2", 32'(state), 1);
    step(1, 8'hAA, 0); chk("rs_fail3", 32'(fail), 0);
    step(1, 8'h21, 0); chk("rs_state4", 32'(state), 3);
    step(1, 8'h01, 0);
    step(1, 8'h07, 0);
    chk("rs_commit", 32'(commit), 1);
    chk("rs_id", 32'(commit_id), 0);
    chk("rs_data", 32'(commit_data), 8'h07);
    step(1, 8'h55, 0);
    step(1, 8'h77, 0);
    chk("rs_fail77", 32'(fail), 1);
    chk("rs_st77", 32'(state), 0);

    // timeout window
    step(1, 8'h55, 0);
    step(1, 8'hAA, 0);
    idle(15);
    chk("to_none15", 32'(timeout), 0);
    chk("to_st15", 32'(state), 2);
    step(1, 8'h21, 0);
    chk("to_strobe", 32'(timeout), 0);
    chk("to_st3", 32'(state), 3);
    idle(15);
    chk("to_pre", 32'(timeout), 0);
    chk("to_pre_st", 32'(state), 3);
    idle(1);
    chk("to_fire", 32'(timeout), 1);
    chk("to_fire_st", 32'(state), 0);
    idle(1);
    chk("to_pulse", 32'(timeout), 0);
    step(1, 8'h01, 0);
    chk("to_nocommit", 32'(commit), 0);
    chk("to_idle", 32'(state), 0);

    // abort beats an ARMED strobe
    step(1, 8'h55, 0);
    step(1, 8'hAA, 0);
    step(1, 8'h11, 0);
    step(1, 8'h01, 0);
    chk("ab_armed", 32'(state), 4);
    step(1, 8'h5A, 1);
    chk("ab_commit", 32'(commit), 0);
    chk("ab_state", 32'(state), 0);
    chk("ab_data", 32'(commit_data), 8'h07);
    chk("ab_armed0", 32'(armed), 0);

    // async reset mid-sequence after a personality-1 commit
    step(1, 8'h55, 0);
    step(1, 8'hAA, 0);
    step(1, 8'h11, 0);
    step(1, 8'h01, 0);
    step(1, 8'h99, 0);
    chk("ar_id", 32'(commit_id), 1);
    step(1, 8'h55, 0);
    step(1, 8'hAA, 0);
    step(1, 8'h21, 0);
    chk("ar_st3", 32'(state), 3);
    #2 reset = 1'b1;
    #1;
    chk("ar_state", 32'(state), 0);
    chk("ar_id0", 32'(commit_id), 0);
    chk("ar_data0", 32'(commit_data), 0);
    @(negedge clock);
    reset = 1'b0;

`ifdef UNLOCK_SEQ_LOCKOUT_EN
    for (int k = 0; k < 3; k++) begin
      chk("lk_before", 32'(locked), 0);
      step(1, 8'h55, 0);
      step(1, 8'h00, 0);
      chk("lk_fail", 32'(fail), 1);
    end
    chk("lk_locked", 32'(locked), 1);
    step(1, 8'h55, 0);
    chk("lk_ign", 32'(state), 0);
    step(1, 8'hAA, 0);
    step(1, 8'h11, 0);
    step(1, 8'h01, 0);
    step(1, 8'h3C, 0);
    chk("lk_nocommit", 32'(commit), 0);
    step(1, 8'h00, 1);
    chk("lk_abort", 32'(locked), 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("lk_rst", 32'(locked), 0);
    @(negedge clock);
    reset = 1'b0;
    step(1, 8'h55, 0);
    step(1, 8'hAA, 0);
    step(1, 8'h11, 0);
    step(1, 8'h01, 0);
    step(1, 8'h3C, 0);
    chk("lk_commit", 32'(commit), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
